// File: rtl/picoblaze_input_port.sv
// Read side of the KCPSM6 I/O bus.
// - Synchronises and debounces the 16 switches and 4 buttons.
// - Presents them on in_port, addressed by port_id.
// - Keeps a sticky event status register that is cleared when software reads it.
// - Raises a level interrupt on any debounced button or switch event.
module picoblaze_input_port #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sw,
  input  logic [3:0]  btn,
  input  logic [7:0]  port_id,
  input  logic        read_strobe,
  input  logic        interrupt_ack,
  output logic [7:0]  in_port,
  output logic        interrupt,
  output logic [15:0] led
);

  localparam int               N_IN    = 20;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, REQ} irq_state_t;

  // Raw inputs packed as {btn, sw}, so the buttons occupy bits 19:16.
  logic [N_IN-1:0]            raw;
  logic [N_IN-1:0]            sync_p0;
  logic [N_IN-1:0]            sync_p1;
  logic [N_IN-1:0]            deb;
  logic [N_IN-1:0]            deb_prev;
  logic [N_IN-1:0][CNT_W-1:0] cnt;

  logic [3:0] btn_rise;
  logic       swlo_chg;
  logic       swhi_chg;
  logic [5:0] ev;
  logic       any_ev;

  logic [5:0] flags;
  logic       ovr;
  logic [7:0] stat;
  logic [6:0] clr_mask;

  irq_state_t state;

  assign raw = {btn, sw};
  assign led = deb[15:0];

  // Two-flop synchroniser for every asynchronous board input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Per-input debounce.
  // The counter runs only while the synchronised level disagrees with the
  // debounced level. Any agreement restarts the count, so a short glitch is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync_p1[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync_p1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Previous debounced levels, used for edge detection.
  // Reset to 0, so inputs already high at reset release later show up as rise events.
  always_ff @(posedge clk) begin
    if (reset) deb_prev <= '0;
    else       deb_prev <= deb;
  end

  // One-cycle event pulses derived from the debounced levels.
  always_comb begin
    btn_rise = deb[19:16] & ~deb_prev[19:16];
    swlo_chg = |(deb[7:0]  ^ deb_prev[7:0]);
    swhi_chg = |(deb[15:8] ^ deb_prev[15:8]);
    ev       = {swhi_chg, swlo_chg, btn_rise};
    any_ev   = |ev;
  end

  assign stat = {1'b0, ovr, flags};

  // A status read clears only the bits software actually saw.
  // Those are the bits latched on in_port when the strobe arrives.
  assign clr_mask = (read_strobe && (port_id == 8'h03)) ? in_port[6:0] : 7'h00;

  // Sticky status flags.
  // A same-cycle event overrides the clear.
  // ovr records an event landing on a flag that is still set.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
      ovr   <= 1'b0;
    end else begin
      flags <= (flags & ~clr_mask[5:0]) | ev;
      ovr   <= (ovr & ~clr_mask[6]) | (|(ev & flags));
    end
  end

  // Registered read mux.
  // The one-cycle latency fits the two-cycle KCPSM6 INPUT window.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_port <= 8'h00;
    end else begin
      case (port_id)
        8'h00:   in_port <= deb[7:0];
        8'h01:   in_port <= deb[15:8];
        8'h02:   in_port <= {4'b0000, deb[19:16]};
        8'h03:   in_port <= stat;
        8'h04:   in_port <= 8'hA5;
        default: in_port <= 8'h00;
      endcase
    end
  end

  // Interrupt request FSM.
  // An event arriving together with the acknowledge keeps the request pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      interrupt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_ev) begin
            state     <= REQ;
            interrupt <= 1'b1;
          end
        end
        REQ: begin
          if (interrupt_ack && !any_ev) begin
            state     <= IDLE;
            interrupt <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picoblaze_input_port.sv
// Directed bench for picoblaze_input_port with DEBOUNCE_CYCLES=4.
module tb_picoblaze_input_port;

  logic        clk;
  logic        reset;
  logic [15:0] sw;
  logic [3:0]  btn;
  logic [7:0]  port_id;
  logic        read_strobe;
  logic        interrupt_ack;
  logic [7:0]  in_port;
  logic        interrupt;
  logic [15:0] led;

  int checks = 0;
  int errors = 0;

  picoblaze_input_port #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .btn(btn),
    .port_id(port_id),
    .read_strobe(read_strobe),
    .interrupt_ack(interrupt_ack),
    .in_port(in_port),
    .interrupt(interrupt),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] pid, input logic [7:0] exp, input string tag);
    port_id = pid;
    cyc(1);
    chk(tag, {8'h00, in_port}, {8'h00, exp});
  endtask

  task automatic clr_stat();
    port_id = 8'h03;
    cyc(1);
    read_strobe = 1'b1;
    cyc(1);
    read_strobe = 1'b0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    cyc(1);
    interrupt_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sw = 16'h0000; btn = 4'h0; port_id = 8'h00;
    read_strobe = 1'b0; interrupt_ack = 1'b0;
    cyc(3);
    chk("rst_in_port", {8'h00, in_port}, 16'h0000);
    chk("rst_interrupt", {15'h0, interrupt}, 16'h0000);
    chk("rst_led", led, 16'h0000);
    reset = 1'b0;
    cyc(1);

    // Switch pattern: latency of 2+4 cycles to led, event one cycle later
    sw = 16'h1234;
    cyc(5);
    chk("sw_led_before_latency", led, 16'h0000);
    cyc(1);
    chk("sw_led", led, 16'h1234);
    chk("sw_int_not_yet", {15'h0, interrupt}, 16'h0000);
    cyc(1);
    chk("sw_int", {15'h0, interrupt}, 16'h0001);
    rd(8'h00, 8'h34, "port0");
    rd(8'h01, 8'h12, "port1");
    rd(8'h03, 8'h30, "stat_sw");
    rd(8'h02, 8'h00, "port2_idle");
    ack();
    chk("sw_int_acked", {15'h0, interrupt}, 16'h0000);
    clr_stat();
    rd(8'h03, 8'h00, "stat_sw_cleared");

    // Two-cycle glitch on btn[0] must be filtered
    btn = 4'b0001;
    cyc(2);
    btn = 4'b0000;
    cyc(10);
    rd(8'h02, 8'h00, "glitch_btn");
    rd(8'h03, 8'h00, "glitch_stat");
    chk("glitch_int", {15'h0, interrupt}, 16'h0000);

    // btn[2] press, ack, then clear-on-read
    btn = 4'b0100;
    cyc(8);
    rd(8'h02, 8'h04, "btn2_level");
    rd(8'h03, 8'h04, "btn2_stat");
    chk("btn2_int", {15'h0, interrupt}, 16'h0001);
    ack();
    chk("btn2_int_acked", {15'h0, interrupt}, 16'h0000);
    rd(8'h03, 8'h04, "btn2_stat_after_ack");
    clr_stat();
    rd(8'h03, 8'h00, "btn2_stat_cleared");
    btn = 4'b0000;
    cyc(8);
    rd(8'h03, 8'h00, "btn2_release_stat");
    chk("btn2_release_int", {15'h0, interrupt}, 16'h0000);

    // btn[1] second rise while its flag is still set -> ovr
    btn = 4'b0010;
    cyc(8);
    rd(8'h03, 8'h02, "btn1_stat");
    btn = 4'b0000;
    cyc(8);
    btn = 4'b0010;
    cyc(8);
    rd(8'h03, 8'h42, "btn1_ovr_stat");
    chk("btn1_int", {15'h0, interrupt}, 16'h0001);

    // btn[3] event lands on the same edge as interrupt_ack
    btn = 4'b1010;
    cyc(6);
    interrupt_ack = 1'b1;
    cyc(1);
    interrupt_ack = 1'b0;
    chk("ack_with_event_int", {15'h0, interrupt}, 16'h0001);
    cyc(1);
    chk("ack_with_event_int_hold", {15'h0, interrupt}, 16'h0001);
    rd(8'h03, 8'h4A, "btn3_stat");
    clr_stat();
    ack();
    chk("btn3_int_acked", {15'h0, interrupt}, 16'h0000);
    chk("btn3_stat_cleared", {8'h00, in_port}, 16'h0000);

    // Event on the same edge as a clear-read of STAT: the flag survives
    sw = 16'h5634;
    cyc(8);
    rd(8'h03, 8'h20, "swhi_stat");
    sw = 16'h7834;
    cyc(6);
    read_strobe = 1'b1;
    cyc(1);
    read_strobe = 1'b0;
    chk("clr_race_latched", {8'h00, in_port}, 16'h0020);
    cyc(1);
    chk("clr_race_stat", {8'h00, in_port}, 16'h0060);

    // ID and unmapped ports
    rd(8'h04, 8'hA5, "port_id_reg");
    rd(8'h07, 8'h00, "port_unmapped7");
    rd(8'hFF, 8'h00, "port_unmappedff");

    // Reset mid-debounce with interrupt pending
    rd(8'h00, 8'h34, "pre_reset_port0");
    chk("pre_reset_int", {15'h0, interrupt}, 16'h0001);
    sw = 16'hFFFF;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    chk("midrst_in_port", {8'h00, in_port}, 16'h0000);
    chk("midrst_interrupt", {15'h0, interrupt}, 16'h0000);
    chk("midrst_led", led, 16'h0000);
    cyc(1);
    reset = 1'b0;
    cyc(8);
    chk("post_rst_led", led, 16'hFFFF);
    chk("post_rst_int", {15'h0, interrupt}, 16'h0001);
    rd(8'h03, 8'h3A, "post_rst_stat");
    rd(8'h02, 8'h0A, "post_rst_btn");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
